// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, bubble insertion, flush and stall counter.
// Define EX_MEM_SKID_EN for a two-entry stage (head + skid) with a registered in_ready.
module ex_mem_stage #(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 7,
  parameter int                RD_W        = 5,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] sw_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [RD_W-1:0]   regdst_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] sw_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [RD_W-1:0]   regdst_out,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt
);

  localparam int E_W = 2*DATA_W + CTRL_W + RD_W;
  localparam logic [E_W-1:0] BUBBLE = {{(2*DATA_W){1'b0}}, CTRL_BUBBLE, {RD_W{1'b0}}};

  logic [E_W-1:0] head_q;
  logic           head_v;
  logic [E_W-1:0] in_entry;
  logic           accept;
  logic           pop;

  assign in_entry    = {alu_in, sw_in, control_in, regdst_in};
  assign out_valid   = head_v;
  // Empty slots hold the bubble pattern, so outputs come straight from flops.
  assign alu_out     = head_q[E_W-1 -: DATA_W];
  assign sw_out      = head_q[E_W-DATA_W-1 -: DATA_W];
  assign control_out = head_q[RD_W +: CTRL_W];
  assign regdst_out  = head_q[RD_W-1:0];
  assign accept      = in_valid & in_ready;
  assign pop         = head_v & out_ready;

`ifdef EX_MEM_SKID_EN
  logic [E_W-1:0] skid_q;
  logic           skid_v;
  logic           in_ready_q;
  logic [1:0]     occ_next;

  assign in_ready  = in_ready_q;
  assign occupancy = {1'b0, head_v} + {1'b0, skid_v};
  assign occ_next  = occupancy + {1'b0, accept} - {1'b0, pop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= BUBBLE;
      head_v     <= 1'b0;
      skid_q     <= BUBBLE;
      skid_v     <= 1'b0;
      in_ready_q <= 1'b1;
      stall_cnt  <= 16'h0;
    end else if (flush) begin
      head_q     <= BUBBLE;
      head_v     <= 1'b0;
      skid_q     <= BUBBLE;
      skid_v     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (head_v) begin
            skid_q <= in_entry;
            skid_v <= 1'b1;
          end else begin
            head_q <= in_entry;
            head_v <= 1'b1;
          end
        end
        2'b01: begin
          if (skid_v) begin
            head_q <= skid_q;
            skid_q <= BUBBLE;
            skid_v <= 1'b0;
          end else begin
            head_q <= BUBBLE;
            head_v <= 1'b0;
          end
        end
        2'b11: begin
          if (skid_v) begin
            head_q <= skid_q;
            skid_q <= in_entry;
          end else begin
            head_q <= in_entry;
          end
        end
        default: ;
      endcase
      in_ready_q <= (occ_next != 2'd2);
      if (head_v && !out_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // Single slot: a full stage can only take a new entry while the head leaves.
  assign in_ready  = out_ready | ~head_v;
  assign occupancy = {1'b0, head_v};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= BUBBLE;
      head_v    <= 1'b0;
      stall_cnt <= 16'h0;
    end else if (flush) begin
      head_q <= BUBBLE;
      head_v <= 1'b0;
    end else begin
      if (accept) begin
        head_q <= in_entry;
        head_v <= 1'b1;
      end else if (pop) begin
        head_q <= BUBBLE;
        head_v <= 1'b0;
      end
      if (head_v && !out_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; expectations follow EX_MEM_SKID_EN when defined.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_in = '0;
  logic [31:0] sw_in = '0;
  logic [6:0]  control_in = '0;
  logic [4:0]  regdst_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_out;
  logic [31:0] sw_out;
  logic [6:0]  control_out;
  logic [4:0]  regdst_out;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_in(alu_in), .sw_in(sw_in), .control_in(control_in), .regdst_in(regdst_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .sw_out(sw_out), .control_out(control_out), .regdst_out(regdst_out),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] s,
                       input logic [6:0] c, input logic [4:0] r);
    in_valid   = v;
    alu_in     = a;
    sw_in      = s;
    control_in = c;
    regdst_in  = r;
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] s,
                            input logic [6:0] c, input logic [4:0] r);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_alu"},   {32'd0, alu_out},   {32'd0, a});
    check({tag, "_sw"},    {32'd0, sw_out},    {32'd0, s});
    check({tag, "_ctrl"},  {57'd0, control_out}, {57'd0, c});
    check({tag, "_rd"},    {59'd0, regdst_out}, {59'd0, r});
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_alu"},   {32'd0, alu_out},   64'd0);
    check({tag, "_sw"},    {32'd0, sw_out},    64'd0);
    check({tag, "_ctrl"},  {57'd0, control_out}, 64'h01);
    check({tag, "_rd"},    {59'd0, regdst_out}, 64'd0);
    check({tag, "_occ"},   {62'd0, occupancy}, 64'd0);
  endtask

  initial begin
    // Reset values, then release between edges; first edge accepts.
    #12;
    check_bubble("rst");
    check("rst_stall", {48'd0, stall_cnt}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 7'h2A, 5'd9);
    step();
    check_head("single", 32'h0000_1234, 32'hDEAD_BEEF, 7'h2A, 5'd9);
    check("single_occ", {62'd0, occupancy}, 64'd1);
    drive(1'b0, 32'h0, 32'h0, 7'h0, 5'd0);
    step();
    check_bubble("single_drain");

    // Back-pressure: head stable for 5 stalled edges.
    drive(1'b1, 32'h5555_0001, 32'h6666_0002, 7'h33, 5'd3);
    step();
    check("bp_stall0", {48'd0, stall_cnt}, 64'd0);
    drive(1'b0, 32'h0, 32'h0, 7'h0, 5'd0);
    out_ready = 1'b0;
    repeat (5) step();
    check_head("bp", 32'h5555_0001, 32'h6666_0002, 7'h33, 5'd3);
    check("bp_stall5", {48'd0, stall_cnt}, 64'd5);
`ifdef EX_MEM_SKID_EN
    check("bp_in_ready", {63'd0, in_ready}, 64'd1);
`else
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", {63'd0, in_ready}, 64'd1);
`endif

    // Simultaneous accept and pop: next entry replaces head, occupancy unchanged.
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_7777, 32'h0000_8888, 7'h15, 5'd17);
    step();
    check_head("swap", 32'h0000_7777, 32'h0000_8888, 7'h15, 5'd17);
    check("swap_occ", {62'd0, occupancy}, 64'd1);
    check("swap_stall", {48'd0, stall_cnt}, 64'd5);
    drive(1'b0, 32'h0, 32'h0, 7'h0, 5'd0);
    step();
    check_bubble("swap_drain");

`ifdef EX_MEM_SKID_EN
    // Skid: stall head, accept A then B, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0000, 32'hA5A5_0000, 7'h0A, 5'd10);
    step();
    drive(1'b1, 32'hBBBB_0000, 32'hB5B5_0000, 7'h0B, 5'd11);
    step();
    check("skid_occ2", {62'd0, occupancy}, 64'd2);
    check("skid_in_ready", {63'd0, in_ready}, 64'd0);
    check_head("skid_a_hold", 32'hAAAA_0000, 32'hA5A5_0000, 7'h0A, 5'd10);
    drive(1'b1, 32'hCCCC_0000, 32'hC5C5_0000, 7'h0C, 5'd12);
    out_ready = 1'b1;
    step();
    check_head("skid_b", 32'hBBBB_0000, 32'hB5B5_0000, 7'h0B, 5'd11);
    check("skid_occ1", {62'd0, occupancy}, 64'd1);
    drive(1'b0, 32'h0, 32'h0, 7'h0, 5'd0);
    step();
    check_bubble("skid_drain");
    check("skid_stall", {48'd0, stall_cnt}, 64'd6);
`endif

    // Flush while stalled with a pending input: all entries and the input dropped.
    out_ready = 1'b0;
`ifdef EX_MEM_SKID_EN
    drive(1'b1, 32'hAAAA_1111, 32'h0, 7'h21, 5'd1);
    step();
    drive(1'b1, 32'hBBBB_2222, 32'h0, 7'h22, 5'd2);
    step();
    check("fl_pre_occ", {62'd0, occupancy}, 64'd2);
`else
    out_ready = 1'b1;
    drive(1'b1, 32'hAAAA_1111, 32'h0, 7'h21, 5'd1);
    step();
    out_ready = 1'b0;
    check("fl_pre_occ", {62'd0, occupancy}, 64'd1);
`endif
    drive(1'b1, 32'hDEAD_0C0C, 32'h0, 7'h7F, 5'd31);
    flush = 1'b1;
    step();
    check_bubble("flush_stall");
`ifdef EX_MEM_SKID_EN
    check("flush_stall_cnt", {48'd0, stall_cnt}, 64'd7);
`else
    check("flush_stall_cnt", {48'd0, stall_cnt}, 64'd5);
`endif

    // Flush colliding with accept and pop.
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_00E1, 32'h0, 7'h11, 5'd4);
    step();
    drive(1'b1, 32'hDEAD_0D0D, 32'h0, 7'h7E, 5'd30);
    flush = 1'b1;
    step();
    check_bubble("flush_coll");
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 7'h0, 5'd0);
    step();
    check_bubble("flush_after");

    // Async reset between edges with one entry held.
    drive(1'b1, 32'h0000_0D0D, 32'h1, 7'h05, 5'd7);
    step();
    drive(1'b0, 32'h0, 32'h0, 7'h0, 5'd0);
    out_ready = 1'b0;
    check("ar_pre_occ", {62'd0, occupancy}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_bubble("async_rst");
    check("async_rst_stall", {48'd0, stall_cnt}, 64'd0);
    reset = 1'b1;

    // Saturation: 70000 stalled edges.
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_5A5A, 32'h2, 7'h06, 5'd8);
    step();
    drive(1'b0, 32'h0, 32'h0, 7'h0, 5'd0);
    out_ready = 1'b0;
    repeat (65534) step();
    check("sat_fffe", {48'd0, stall_cnt}, 64'hFFFE);
    step();
    check("sat_ffff", {48'd0, stall_cnt}, 64'hFFFF);
    repeat (4465) step();
    check("sat_hold", {48'd0, stall_cnt}, 64'hFFFF);
    check_head("sat_head", 32'h0000_5A5A, 32'h2, 7'h06, 5'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of the ALU result and store-data paths.
REQ-002 Parameter CTRL_W, default 7, SHALL set the width of the control bundle.
REQ-003 Parameter RD_W, default 5, SHALL set the width of the destination-register index.
REQ-004 Parameter CTRL_BUBBLE, default 1 (CTRL_W bits), SHALL set the control value driven for an empty slot.
REQ-005 Ports SHALL be, in order:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept.
- alu_in  in  DATA_W  ALU result.
- sw_in  in  DATA_W  store data.
- control_in  in  CTRL_W  control bundle.
- regdst_in  in  RD_W  destination register.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts.
- alu_out  out  DATA_W  head ALU result.
- sw_out  out  DATA_W  head store data.
- control_out  out  CTRL_W  head control bundle.
- regdst_out  out  RD_W  head destination register.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  16  saturating count of back-pressured cycles.

Function
REQ-006 An entry SHALL be accepted on a rising clk edge with in_valid=1 and in_ready=1, and SHALL be popped on a rising clk edge with out_valid=1 and out_ready=1.
REQ-007 Latency SHALL be one cycle: an entry accepted at edge N SHALL be visible on the outputs after edge N when the stage was empty.
REQ-008 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or lost except by flush.
REQ-009 With out_valid=0, the outputs SHALL be alu_out=0, sw_out=0, regdst_out=0, and control_out=CTRL_BUBBLE.
REQ-010 When the last entry pops and nothing is accepted, the outputs SHALL take the bubble values on the same edge.
REQ-011 Simultaneous accept and pop SHALL keep occupancy unchanged and SHALL present the next entry after the edge.
REQ-012 A flush=1 edge SHALL set occupancy to 0 and the outputs to bubble values.
REQ-013 On a flush=1 edge, flush SHALL override any simultaneous accept or pop, and the input entry SHALL be discarded.
REQ-014 The occupancy output SHALL equal the number of held entries at all times.
REQ-015 stall_cnt SHALL increment on each edge with out_valid=1, out_ready=0 and flush=0.
REQ-016 stall_cnt SHALL saturate at 16'hFFFF.
REQ-017 stall_cnt SHALL be unaffected by flush.

Reset
REQ-018 reset=0 SHALL asynchronously force alu_out=0, sw_out=0, regdst_out=0, control_out=CTRL_BUBBLE, out_valid=0, occupancy=0 and stall_cnt=0.
REQ-019 In the configuration of REQ-022, reset=0 SHALL also force in_ready=1.
REQ-020 Reset asserted mid-transfer SHALL discard all held entries, with no partial entry surviving.
REQ-021 After reset deasserts, the first accept SHALL be possible on the first rising clk edge.

Configuration
REQ-022 With macro EX_MEM_SKID_EN defined, the stage SHALL hold up to 2 entries (head plus skid).
REQ-023 With EX_MEM_SKID_EN defined, in_ready SHALL be registered and equal to (occupancy<2), with no combinational path from out_ready.
REQ-024 With EX_MEM_SKID_EN defined, an entry accepted while the head is stalled SHALL be placed in the skid slot and SHALL move to the head on the next pop.
REQ-025 Without EX_MEM_SKID_EN, the stage SHALL hold at most 1 entry, and in_ready SHALL equal out_ready OR NOT out_valid (combinational).
REQ-026 Without EX_MEM_SKID_EN, occupancy SHALL never exceed 1.

Verification
REQ-027 Reset then single entry: accept alu_in=32'h0000_1234, sw_in=32'hDEAD_BEEF, control_in=7'h2A, regdst_in=5'd9 with out_ready=1 -> the outputs SHALL show these values after 1 edge, then bubble values (control_out=7'h01) after the next edge.
REQ-028 Back-pressure: hold out_ready=0 for 5 edges with the head valid -> the outputs SHALL be stable and stall_cnt SHALL be 5.
REQ-029 Skid (EX_MEM_SKID_EN): stall the head and accept A then B -> occupancy SHALL be 2 and in_ready=0; with out_ready=1, A then B SHALL appear on consecutive edges.
REQ-030 Flush collision: flush=1 with in_valid=1 and occupancy=2 -> occupancy SHALL be 0, out_valid=0 and the outputs SHALL be bubble values; the input entry SHALL never appear.
REQ-031 Async reset mid-stream: drop reset between edges with occupancy=1 -> the outputs SHALL take reset values immediately, without a clk edge.
REQ-032 Saturation: force 70000 stalled cycles -> stall_cnt SHALL read 16'hFFFF.
